// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer for the 8-bit ALU: accepts one instruction per handshake,
// drives the ALU from a 4-entry register file and writes the result and flags back.
module alu_exec_seq #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_load,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_rst,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_c_out,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              done,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_v,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              load_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [2:0]        alu_op_q;
  logic              accept;

  assign instr_ready = (state_q == S_IDLE) && rst_n;
  assign accept      = instr_valid && instr_ready;
  assign done        = (state_q == S_WB);
  assign alu_rst     = (state_q != S_EXEC);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign dbg_data    = regs[dbg_sel];

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are captured at accept; no write can land on that edge, so they
  // equal regs[rd]/regs[rs] throughout EXEC and hold their values afterwards.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      load_q   <= 1'b0;
      rd_q     <= '0;
      imm_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        load_q   <= instr_load;
        rd_q     <= instr_rd;
        imm_q    <= instr_imm;
        alu_a_q  <= regs[instr_rd];
        alu_b_q  <= regs[instr_rs];
        alu_op_q <= instr_op;
      end
    end
  end

  // Architectural state: register file and status flags, written only at EXEC->WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the register file is architecturally visible and must read zero after reset,
      // so it is built from resettable flops rather than an unreset RAM.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else if (state_q == S_EXEC) begin
      if (load_q) begin
        regs[rd_q] <= imm_q;
      end else begin
        regs[rd_q] <= alu_res;
        flag_c     <= alu_c_out;
        flag_z     <= alu_zero;
        flag_v     <= alu_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq: a behavioural ALU stub, an in-bench architectural
// model producing expected writebacks, and a monitor that checks every done pulse.
module tb_alu_exec_seq;

  localparam int DW = 8;
  localparam int AW = 2;

  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_XOR = 3'd2, OP_NOT = 3'd3,
                         OP_ADD = 3'd4, OP_SUB = 3'd5, OP_INC = 3'd6, OP_DEC = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid, instr_ready, instr_load;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs, dbg_sel;
  logic [DW-1:0] instr_imm, alu_a, alu_b, alu_res, dbg_data;
  logic [2:0]    alu_op;
  logic          alu_rst, alu_c_out, alu_zero, alu_ovf;
  logic          done, flag_c, flag_z, flag_v;

  alu_exec_seq #(.DATA_W(DW), .NUM_REGS(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_load(instr_load),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rst(alu_rst),
    .alu_res(alu_res), .alu_c_out(alu_c_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .done(done), .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU behaviour from integer arithmetic: carry = unsigned result out of 0..255,
  // overflow = signed result out of -128..127.
  function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, ur, sr;
    logic [7:0] res;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; ur = 0; sr = 0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      default: begin
        case (op)
          OP_ADD:  begin ur = ua + ub; sr = sa + sb; end
          OP_SUB:  begin ur = ua - ub; sr = sa - sb; end
          OP_INC:  begin ur = ua + 1;  sr = sa + 1;  end
          default: begin ur = ua - 1;  sr = sa - 1;  end
        endcase
        res = 8'(ur & 255);
        c = (ur < 0) || (ur > 255);
        v = (sr < -128) || (sr > 127);
      end
    endcase
    return {c, (res == 8'h00), v, res};
  endfunction

  always_comb begin
    alu_res = '0; alu_c_out = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0;
    if (!alu_rst) {alu_c_out, alu_zero, alu_ovf, alu_res} = alu_fn(alu_op, alu_a, alu_b);
  end

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] val;
    logic          c, z, v;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mregs [4];
  logic          mc, mz, mv;
  int            n_cmp = 0, n_err = 0, done_cnt = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every done pulse retires the oldest expected writeback.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_cnt++;
        check("done_ready_excl", instr_ready, 0);
        check("alu_rst_in_wb", alu_rst, 1);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          dbg_sel = e.rd;
          #1;
          check("wb_value", dbg_data, e.val);
          check("wb_flags", {flag_c, flag_z, flag_v}, {e.c, e.z, e.v});
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    {mc, mz, mv} = 3'b000;
  endtask

  // Drive one instruction and wait for acceptance; the model updates at the accept edge.
  task automatic issue(input logic ld, input logic [2:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs, input logic [DW-1:0] imm,
                       input bit retire, output int acc_cyc);
    bit   acc;
    exp_t e;
    logic [10:0] r;
    @(negedge clk);
    instr_valid = 1'b1; instr_load = ld; instr_op = op;
    instr_rd = rd; instr_rs = rs; instr_imm = imm;
    acc = 0;
    acc_cyc = -1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (instr_ready) begin
        @(posedge clk);
        acc = 1;
        acc_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
    end else if (retire) begin
      if (ld) begin
        mregs[rd] = imm;
      end else begin
        r = alu_fn(op, mregs[rd], mregs[rs]);
        mregs[rd] = r[7:0];
        {mc, mz, mv} = r[10:8];
      end
      e.rd = rd; e.val = mregs[rd]; e.c = mc; e.z = mz; e.v = mv;
      sb_q.push_back(e);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    check("drain_empty", sb_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [AW-1:0] r, output logic [DW-1:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  initial begin
    int            a0, a1, a2, d0;
    logic [DW-1:0] rv;
    rst_n = 1'b0; instr_valid = 1'b0; instr_load = 1'b0; instr_op = '0;
    instr_rd = '0; instr_rs = '0; instr_imm = '0; dbg_sel = '0;
    model_reset();

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", instr_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", instr_ready, 1);
    check("done_after_rst", done, 0);
    check("flags_after_rst", {flag_c, flag_z, flag_v}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      read_reg(AW'(i), rv);
      check("reg_after_rst", rv, 0);
    end

    // Load then ADD: done pulses 3 cycles apart
    d0 = done_cnt;
    issue(1, OP_AND, 0, 0, 8'h7F, 1, a0);
    issue(1, OP_AND, 1, 0, 8'h01, 1, a1);
    issue(0, OP_ADD, 0, 1, 8'h00, 1, a2);
    go_idle();
    drain();
    check("load_add_gap1", a1 - a0, 3);
    check("load_add_gap2", a2 - a1, 3);
    check("load_add_dones", done_cnt - d0, 3);
    read_reg(0, rv);
    check("add_r0", rv, 8'h80);
    check("add_flags_cvz", {flag_c, flag_v, flag_z}, 3'b010);

    // Carry and zero, then a load leaves flags alone
    issue(1, OP_AND, 2, 0, 8'hFF, 1, a0);
    issue(0, OP_INC, 2, 3, 8'h00, 1, a0);
    go_idle();
    drain();
    read_reg(2, rv);
    check("inc_r2", rv, 8'h00);
    check("inc_flags_cz", {flag_c, flag_z}, 2'b11);
    issue(1, OP_AND, 3, 0, 8'h05, 1, a0);
    go_idle();
    drain();
    check("load_keeps_flags", {flag_c, flag_z, flag_v}, 3'b110);

    // Same-register SUB
    issue(1, OP_AND, 1, 0, 8'h33, 1, a0);
    issue(0, OP_SUB, 1, 1, 8'h00, 1, a0);
    go_idle();
    drain();
    read_reg(1, rv);
    check("sub_same_r1", rv, 8'h00);
    check("sub_same_zv", {flag_z, flag_v}, 2'b10);

    // Handshake: valid held high across three queued instructions
    d0 = done_cnt;
    issue(1, OP_AND, 0, 0, 8'hA5, 1, a0);
    issue(0, OP_XOR, 0, 3, 8'h00, 1, a1);
    issue(0, OP_DEC, 3, 0, 8'h00, 1, a2);
    go_idle();
    drain();
    check("hs_gap1", a1 - a0, 3);
    check("hs_gap2", a2 - a1, 3);
    check("hs_dones", done_cnt - d0, 3);
    read_reg(0, rv);
    check("hs_r0", rv, 8'hA0);
    read_reg(3, rv);
    check("hs_r3", rv, 8'h04);

    // Reset during EXEC of ADD r0,r1 aborts it
    issue(1, OP_AND, 0, 0, 8'h10, 1, a0);
    issue(1, OP_AND, 1, 0, 8'h20, 1, a0);
    go_idle();
    drain();
    d0 = done_cnt;
    issue(0, OP_ADD, 0, 1, 8'h00, 0, a0);
    @(negedge clk);
    check("exec_alu_rst", alu_rst, 0);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_ready", instr_ready, 1);
    read_reg(0, rv);
    check("abort_r0", rv, 8'h00);
    check("abort_flags", {flag_c, flag_z, flag_v}, 3'b000);

    // Randomised traffic against the model
    for (int n = 0; n < 80; n++) begin
      issue(1'($urandom_range(0, 3) == 0), 3'($urandom), 2'($urandom), 2'($urandom),
            8'($urandom), 1, a0);
      if ($urandom_range(0, 1) == 1) begin
        go_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    go_idle();
    drain();
    for (int i = 0; i < 4; i++) begin
      read_reg(AW'(i), rv);
      check("final_reg", rv, mregs[i]);
    end
    check("final_flags", {flag_c, flag_z, flag_v}, {mc, mz, mv});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
Execute-stage sequencer wrapped around the 8-bit ALU. It accepts one instruction per valid/ready handshake and reads two operands from an internal 4-entry register file. It drives the ALU operand and opcode inputs, then writes the ALU result back to the register file and latches the carry, zero and overflow flags into a status register. It sits between the instruction source (decoder/test harness) and the combinational ALU, and is the only writer of architectural register state.

Parameters:
DATA_W, 8, datapath width; must equal ALU width (only 8 supported)
NUM_REGS, 4, register-file depth
ADDR_W, 2, register index width (log2 NUM_REGS)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
instr_valid  input  1  instruction present
instr_ready  output  1  sequencer can accept (high only in IDLE, low while rst_n=0)
instr_load  input  1  1 = load-immediate, 0 = ALU op
instr_op  input  3  ALU opcode (000 AND … 111 DEC, ALU encoding)
instr_rd  input  ADDR_W  destination and operand-A register
instr_rs  input  ADDR_W  operand-B register
instr_imm  input  DATA_W  immediate for load
alu_a  output  DATA_W  to ALU a
alu_b  output  DATA_W  to ALU b
alu_op  output  3  to ALU op
alu_rst  output  1  to ALU rst; high in every state except EXEC
alu_res  input  DATA_W  from ALU res
alu_c_out  input  1  from ALU c_out
alu_zero  input  1  from ALU zero
alu_ovf  input  1  from ALU ovf
done  output  1  one-cycle pulse: instruction retired
flag_c, flag_z, flag_v  output  1 each  registered status flags
dbg_sel  input  ADDR_W  register-file read select
dbg_data  output  DATA_W  combinational read of regs[dbg_sel]

Behaviour:
- Reset (rst_n=0 at clk edge): all regs = 0; flags = 0; state = IDLE; done = 0; latched instruction fields = 0. instr_ready is forced 0 while rst_n=0. Reset mid-instruction aborts it with no writeback and no done.
- FSM: IDLE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch load, op, rd, rs and imm, then go to EXEC. Otherwise stay in IDLE. Input changes while in IDLE without valid are ignored.
- EXEC (exactly 1 cycle): alu_rst=0, alu_a=regs[rd_q], alu_b=regs[rs_q], alu_op=op_q.
  - ALU op (load_q=0): at the EXEC->WB edge, regs[rd_q]<=alu_res and {flag_c,flag_z,flag_v}<={alu_c_out,alu_zero,alu_ovf}.
  - Load (load_q=1): regs[rd_q]<=imm_q; flags unchanged. ALU outputs are ignored.
- WB (1 cycle): done=1; instr_ready=0; return to IDLE.
- Timing: with accept at edge N, writeback lands at N+1, done is high N+1..N+2, and the next accept is possible at edge N+3. Throughput is one instruction per 3 cycles.
- Outside EXEC, alu_a, alu_b and alu_op hold their last values; alu_rst=1, so the ALU outputs zeros.
- rd==rs is legal: both operands read the same register.
- Unary ops (NOT/INC/DEC) still drive alu_b=regs[rs_q]; the ALU ignores it.
- Arithmetic is 8-bit. Wrap-around is whatever the ALU produces (e.g. 0xFF INC -> 0x00, c_out follows ALU temp[8]). The sequencer does no arithmetic of its own.
- dbg_data shows the pre-write value during EXEC and the new value from the WB cycle onward.
- done and instr_ready are never high in the same cycle.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> all regs 0 via dbg, flags 0, instr_ready=1 on the first cycle after release, done=0.
- Load then ADD: load r0=0x7F and r1=0x01, then ADD rd=0 rs=1 -> r0=0x80, flag_v=1, flag_c=0, flag_z=0; done pulses exactly once per instruction, 3 cycles apart.
- Carry and zero: load r2=0xFF, then INC rd=2 -> r2=0x00, flag_c=1, flag_z=1; a subsequent load r3=0x05 leaves the flags unchanged.
- Same-register SUB: load r1=0x33, then SUB rd=1 rs=1 -> r1=0x00, flag_z=1, flag_v=0.
- Handshake: hold instr_valid=1 continuously with 3 queued instructions -> instr_ready pulses once per 3 cycles, exactly 3 done pulses, and regs match the in-order result.
- Reset mid-op: assert rst_n=0 during the EXEC of ADD r0,r1 (r0=0x10, r1=0x20) -> no done, r0=0x00 after reset, state IDLE.
